// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks a one-hot row drive, debounces the first key seen
// with one shared counter, and emits a single valid pulse with the key code per press.
module keypad_scanner #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int delay  = 50000,
  parameter int SETTLE = 4
) (
  input  logic                            ck,
  input  logic                            reset,
  input  logic [COLS-1:0]                 col,
  output logic [ROWS-1:0]                 row,
  output logic [$clog2(ROWS*COLS)-1:0]    code,
  output logic                            valid,
  output logic                            held
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(ROWS*COLS);
  localparam int DW = $clog2(delay+1);
  localparam int SW = $clog2(SETTLE+1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESS,
    RELEASE
  } state_t;

  state_t state, state_next;

  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] cs;
  logic [RW-1:0]   row_idx, row_idx_next, row_idx_inc;
  logic [SW-1:0]   settle, settle_next;
  logic [DW-1:0]   count, count_next;
  logic [CW-1:0]   sel, sel_next, low_col;
  logic [KW-1:0]   code_next;
  logic            key_level;

  // Two-flop synchronizer; the column pins are asynchronous to ck.
  always_ff @(posedge ck) begin
    if (reset) begin
      col_meta <= '0;
      cs       <= '0;
    end else begin
      col_meta <= col;
      cs       <= col_meta;
    end
  end

  always_comb begin
    low_col = '0;
    for (int j = COLS-1; j >= 0; j--) begin
      if (cs[j]) low_col = CW'(j);
    end
  end

  assign row_idx_inc = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;
  assign key_level   = cs[sel];

  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= '0;
      settle  <= '0;
      count   <= '0;
      sel     <= '0;
      code    <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_idx_next;
      settle  <= settle_next;
      count   <= count_next;
      sel     <= sel_next;
      code    <= code_next;
    end
  end

  // The settle and debounce counters saturate at their terminal values and never wrap.
  always_comb begin
    state_next   = state;
    row_idx_next = row_idx;
    settle_next  = settle;
    count_next   = count;
    sel_next     = sel;
    code_next    = code;
    case (state)
      SCAN: begin
        if (settle != SW'(SETTLE)) begin
          settle_next = settle + 1'b1;
        end else if (cs == '0) begin
          row_idx_next = row_idx_inc;
          settle_next  = '0;
        end else begin
          sel_next   = low_col;
          count_next = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!key_level) begin
          settle_next = '0;
          state_next  = SCAN;
        end else if (count == DW'(delay-1)) begin
          count_next = DW'(delay);
          code_next  = KW'(int'(row_idx) * COLS + int'(sel));
          state_next = PRESS;
        end else begin
          count_next = count + 1'b1;
        end
      end
      PRESS: begin
        count_next = '0;
        state_next = RELEASE;
      end
      RELEASE: begin
        if (key_level) begin
          count_next = '0;
        end else if (count == DW'(delay-1)) begin
          count_next   = DW'(delay);
          row_idx_next = row_idx_inc;
          settle_next  = '0;
          state_next   = SCAN;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase
  end

  assign row   = {{(ROWS-1){1'b0}}, 1'b1} << row_idx;
  assign valid = (state == PRESS);
  assign held  = (state == PRESS) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner on a 4x4 keypad with delay=5, SETTLE=4; the
// keypad is modelled as col[j] = OR over rows of (row[r] & pressed[r][j]).
module tb_keypad_scanner;

  logic       ck;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] code;
  logic       valid;
  logic       held;

  logic [3:0][3:0] pressed;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_count  = 0;

  keypad_scanner #(
    .ROWS  (4),
    .COLS  (4),
    .delay (5),
    .SETTLE(4)
  ) dut (
    .ck   (ck),
    .reset(reset),
    .col  (col),
    .row  (row),
    .code (code),
    .valid(valid),
    .held (held)
  );

  initial ck = 1'b0;
  always #10 ck = ~ck;

  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && row[r]) col[c] = 1'b1;
      end
    end
  end

  always @(negedge ck) begin
    if (valid === 1'b1) valid_count++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Free-running scan position: row index idx0 at sample k0, five samples per row.
  function automatic logic [3:0] scan_row(int k, int k0, int idx0);
    return 4'b0001 << ((idx0 + (k - k0) / 5) % 4);
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Leaves the sample point right after the last reset edge (k = 0), reset released.
  task automatic do_reset();
    pressed = '0;
    reset   = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    int v0;
    pressed = '0;
    reset   = 1'b1;
    repeat (3) step();
    v0 = valid_count;
    tests_run++;
    if ({row, code, valid, held} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values row/code/valid/held got %b/%0d/%b/%b want 0001/0/0/0",
               row, code, valid, held);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_row = scan_row(k, 0, 0);
      tests_run++;
      if ({row, valid, held} !== {exp_row, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL idle_scan k=%0d row/valid/held got %b/%b/%b want %b/0/0",
                 k, row, valid, held, exp_row);
      end
    end
    tests_run++;
    if (valid_count - v0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_pulses got %0d want 0", valid_count - v0);
    end
  endtask

  task automatic test_single_press();
    logic [3:0] exp_row;
    logic       exp_valid, exp_held;
    int v0;
    do_reset();
    v0 = valid_count;
    pressed[2][1] = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step();
      exp_row   = (k < 10) ? scan_row(k, 0, 0) : (k <= 66) ? 4'b0100 : scan_row(k, 67, 3);
      exp_valid = (k == 20);
      exp_held  = (k >= 20) && (k <= 66);
      tests_run++;
      if ({row, valid, held} !== {exp_row, exp_valid, exp_held}) begin
        tests_failed++;
        $display("[TB] FAIL single_press k=%0d row/valid/held got %b/%b/%b want %b/%b/%b",
                 k, row, valid, held, exp_row, exp_valid, exp_held);
      end
      if (k == 20) begin
        tests_run++;
        if (code !== 4'd9) begin
          tests_failed++;
          $display("[TB] FAIL single_press_code got %0d want 9", code);
        end
      end
      if (k == 60) pressed[2][1] = 1'b0;
    end
    tests_run++;
    if (code !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL code_hold got %0d want 9", code);
    end
    tests_run++;
    if (valid_count - v0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_press_pulses got %0d want 1", valid_count - v0);
    end
  endtask

  task automatic test_short_bounce();
    logic [3:0] exp_row;
    int v0;
    do_reset();
    v0 = valid_count;
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_row = (k < 5) ? scan_row(k, 0, 0) : (k <= 16) ? 4'b0010 : scan_row(k, 17, 2);
      tests_run++;
      if ({row, valid, held} !== {exp_row, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL short_bounce k=%0d row/valid/held got %b/%b/%b want %b/0/0",
                 k, row, valid, held, exp_row);
      end
      if (k == 6) pressed[1][3] = 1'b1;
      if (k == 9) pressed[1][3] = 1'b0;
    end
    tests_run++;
    if (valid_count - v0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL short_bounce_pulses got %0d want 0", valid_count - v0);
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] exp_row;
    logic       exp_valid, exp_held;
    int v0;
    do_reset();
    v0 = valid_count;
    pressed[0][0] = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp_row   = (k <= 30) ? 4'b0001 : scan_row(k, 31, 1);
      exp_valid = (k == 10);
      exp_held  = (k >= 10) && (k <= 30);
      tests_run++;
      if ({row, valid, held} !== {exp_row, exp_valid, exp_held}) begin
        tests_failed++;
        $display("[TB] FAIL release_bounce k=%0d row/valid/held got %b/%b/%b want %b/%b/%b",
                 k, row, valid, held, exp_row, exp_valid, exp_held);
      end
      if (k == 10) begin
        tests_run++;
        if (code !== 4'd0) begin
          tests_failed++;
          $display("[TB] FAIL release_bounce_code got %0d want 0", code);
        end
      end
      if (k == 20) pressed[0][0] = 1'b0;
      if (k == 22) pressed[0][0] = 1'b1;
      if (k == 24) pressed[0][0] = 1'b0;
    end
    tests_run++;
    if (valid_count - v0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL release_bounce_pulses got %0d want 1", valid_count - v0);
    end
  endtask

  task automatic test_multi_key();
    logic [3:0] exp_row;
    logic       exp_valid, exp_held;
    int v0;
    do_reset();
    v0 = valid_count;
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      step();
      exp_row   = (k < 15) ? scan_row(k, 0, 0) : (k <= 56) ? 4'b1000 :
                  (k <= 61) ? 4'b0001 : 4'b0010;
      exp_valid = (k == 25) || (k == 72);
      exp_held  = ((k >= 25) && (k <= 56)) || (k >= 72);
      tests_run++;
      if ({row, valid, held} !== {exp_row, exp_valid, exp_held}) begin
        tests_failed++;
        $display("[TB] FAIL multi_key k=%0d row/valid/held got %b/%b/%b want %b/%b/%b",
                 k, row, valid, held, exp_row, exp_valid, exp_held);
      end
      if (k == 25) begin
        tests_run++;
        if (code !== 4'd12) begin
          tests_failed++;
          $display("[TB] FAIL multi_key_code got %0d want 12", code);
        end
      end
      if (k == 72) begin
        tests_run++;
        if (code !== 4'd5) begin
          tests_failed++;
          $display("[TB] FAIL back_to_back_code got %0d want 5", code);
        end
      end
      if (k == 30) begin
        pressed[3][2] = 1'b0;
        pressed[1][1] = 1'b1;
      end
      if (k == 50) pressed[3][0] = 1'b0;
    end
    pressed = '0;
    tests_run++;
    if (valid_count - v0 != 2) begin
      tests_failed++;
      $display("[TB] FAIL multi_key_pulses got %0d want 2", valid_count - v0);
    end
  endtask

  task automatic test_reset_midway();
    int v0;
    do_reset();
    v0 = valid_count;
    pressed[0][1] = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    reset = 1'b1;
    step();
    tests_run++;
    if ({row, code, valid, held} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_debounce row/code/valid/held got %b/%0d/%b/%b want 0001/0/0/0",
               row, code, valid, held);
    end
    reset   = 1'b0;
    pressed = '0;
    for (int k = 9; k <= 30; k++) begin
      step();
      tests_run++;
      if ({valid, held} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL after_debounce_reset k=%0d valid/held got %b/%b want 0/0",
                 k, valid, held);
      end
    end

    do_reset();
    pressed[0][1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 10) begin
        tests_run++;
        if ({valid, held, code} !== {1'b1, 1'b1, 4'd1}) begin
          tests_failed++;
          $display("[TB] FAIL pre_reset_press valid/held/code got %b/%b/%0d want 1/1/1",
                   valid, held, code);
        end
      end
    end
    reset = 1'b1;
    step();
    tests_run++;
    if ({row, code, valid, held} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_release row/code/valid/held got %b/%0d/%b/%b want 0001/0/0/0",
               row, code, valid, held);
    end
    reset   = 1'b0;
    pressed = '0;
    for (int k = 16; k <= 35; k++) begin
      step();
      tests_run++;
      if ({valid, held} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL after_release_reset k=%0d valid/held got %b/%b want 0/0",
                 k, valid, held);
      end
    end
    tests_run++;
    if (valid_count - v0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL reset_midway_pulses got %0d want 1", valid_count - v0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    pressed = '0;
    test_reset();
    test_single_press();
    test_short_bounce();
    test_release_bounce();
    test_multi_key();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
